lab1_gate_sequencer: RTL
========================

Name: lab1_gate_sequencer

Overview:
Self-checking stimulus controller for the Lab1 gate block (and/or/nand/nor/not outputs from inputs a, b, c).
- On a start request, walks the 3-bit input space 000 -> 111 and holds each vector for a programmable number of cycles.
- On the last hold cycle of each vector, compares the five gate outputs against internally computed expected values.
- Reports a per-run error count, the first failing vector, a sticky mismatch mask and pass/done flags.
- Replaces hand-written #delay stimulus with a synthesizable, clocked sequencer.

Parameters:
HOLD_CYCLES, 20, cycles each vector is driven; legal range 1..2**CNT_W-1.
CNT_W, 8, width of the hold counter.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
seq_a  output  1  DUT input a, equal to vector_idx[2].
seq_b  output  1  DUT input b, equal to vector_idx[1].
seq_c  output  1  DUT input c, equal to vector_idx[0].
L1_andOut  input  1  DUT and output.
L1_orOut  input  1  DUT or output.
L1_nandOut  input  1  DUT nand output.
L1_norOut  input  1  DUT nor output.
L1_notOut_a  input  1  DUT not-a output.
busy  output  1  sweep in progress.
done  output  1  sweep complete; held until the next start or reset.
pass  output  1  valid with done; 1 iff err_count==0.
vector_idx  output  3  current vector index.
err_count  output  4  number of vectors with at least one mismatch (0..8).
first_fail_idx  output  3  index of the first mismatching vector; meaningful only when err_count!=0.
fail_mask  output  5  sticky OR of mismatching outputs, bit order {not_a, nor, nand, or, and}.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on clk, and has priority over every other input.
- Reset values: all outputs 0, including seq_a/b/c, busy, done, pass, vector_idx, err_count, first_fail_idx and fail_mask. Hold counter is 0. State is IDLE.
- Expected values for vector (a,b,c):
  - and = a&b&c
  - or = a|b|c
  - nand = ~(a&b&c)
  - nor = ~(a|b|c)
  - not_a = ~a
- States: IDLE, DRIVE, DONE.
- IDLE/DONE with start=1 at edge T:
  - Next state is DRIVE; busy=1 and done=0 from T+1.
  - vector_idx, hold counter, err_count, first_fail_idx and fail_mask are all cleared to 0.
  - pass is cleared to 0.
- DRIVE:
  - seq_a/b/c are driven combinationally from vector_idx.
  - The hold counter increments every cycle.
  - On the cycle where counter==HOLD_CYCLES-1 (the check cycle), the five DUT outputs are compared against the expected values.
  - On mismatch in the check cycle:
    - err_count increments.
    - fail_mask |= mismatch bits.
    - first_fail_idx <= vector_idx, only if err_count==0 before the update.
  - After the check cycle:
    - If vector_idx==7: next state DONE, busy=0, done=1, pass=(final err_count==0).
    - Otherwise: vector_idx increments and counter resets to 0.
- Timing: each vector is driven for exactly HOLD_CYCLES cycles, so busy is high for 8*HOLD_CYCLES cycles. With start at edge T, done rises at edge T+8*HOLD_CYCLES.
- start while busy is ignored and has no effect on the sweep.
- HOLD_CYCLES=1: every DRIVE cycle is a check cycle, with one vector per clock.
- Reset mid-sweep returns to IDLE with all outputs 0 on the next edge. A partial err_count is discarded.
- err_count does not saturate; the maximum value is 8.
- In IDLE and DONE, seq_a/b/c keep the last vector_idx value (0 after reset, 7 after a sweep).
- The DUT is treated as combinational. A DUT with internal delay is supported when that delay is shorter than HOLD_CYCLES-1 cycles.

Test Plan:
- Correct combinational DUT model, HOLD_CYCLES=4, start pulse at cycle 2 -> busy for 32 cycles, vectors 0..7 in order, done=1, pass=1, err_count=0, fail_mask=00000.
- DUT and output stuck at 0 -> only vector 7 mismatches: err_count=1, first_fail_idx=7, fail_mask=00001, pass=0.
- DUT not_a output inverted -> all 8 vectors mismatch: err_count=8, first_fail_idx=0, fail_mask=10000, pass=0.
- Reset asserted at the 10th busy cycle -> next edge busy=0, done=0, err_count=0, vector_idx=0. A fresh start then completes with pass=1.
- start held high for the whole sweep -> the sweep is not restarted and done appears at 8*HOLD_CYCLES. Because start is still high in DONE, a new sweep begins the next cycle and done drops.
- HOLD_CYCLES=1 with a correct DUT -> vector_idx advances every clock, done 8 cycles after start, pass=1.

Source files
------------

// File: rtl/lab1_gate_sequencer_if.sv
// Stimulus/response bundle between the gate sequencer (master) and the Lab1 gate block (slave).
interface lab1_gate_sequencer_if;
    logic seq_a;
    logic seq_b;
    logic seq_c;
    logic L1_andOut;
    logic L1_orOut;
    logic L1_nandOut;
    logic L1_norOut;
    logic L1_notOut_a;

    modport master (
        output seq_a, seq_b, seq_c,
        input  L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a
    );

    modport slave (
        input  seq_a, seq_b, seq_c,
        output L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a
    );
endinterface

// File: rtl/lab1_gate_sequencer.sv
// Clocked sweep of the 3-bit gate input space: holds each vector, checks the five
// gate outputs on the last hold cycle and accumulates error statistics.
module lab1_gate_sequencer #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    lab1_gate_sequencer_if.master gate,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            vector_idx,
    output logic [3:0]            err_count,
    output logic [2:0]            first_fail_idx,
    output logic [4:0]            fail_mask
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LAST_VEC = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] hold_cnt;

    logic             clear_c;
    logic             check_c;
    logic             last_c;
    logic [4:0]       expected_c;
    logic [4:0]       observed_c;
    logic [4:0]       mismatch_c;
    logic [3:0]       err_next_c;

    assign gate.seq_a = vector_idx[2];
    assign gate.seq_b = vector_idx[1];
    assign gate.seq_c = vector_idx[0];

    // Reference gate values and per-output mismatch, bit order {not_a, nor, nand, or, and}
    always_comb begin
        expected_c = {~vector_idx[2], ~(|vector_idx), ~(&vector_idx), |vector_idx, &vector_idx};
        observed_c = {gate.L1_notOut_a, gate.L1_norOut, gate.L1_nandOut,
                      gate.L1_orOut, gate.L1_andOut};
        mismatch_c = observed_c ^ expected_c;
        err_next_c = err_count + 4'(|mismatch_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      if (last_c) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Control strobes for the datapath registers
    always_comb begin
        clear_c = 1'b0;
        check_c = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE, DONE: clear_c = start;
            DRIVE: begin
                check_c = (hold_cnt == LAST_CNT);
                last_c  = check_c && (vector_idx == LAST_VEC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt       <= '0;
            vector_idx     <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_mask      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else if (clear_c) begin
            hold_cnt       <= '0;
            vector_idx     <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_mask      <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else if (check_c) begin
            if (|mismatch_c) begin
                err_count <= err_next_c;
                fail_mask <= fail_mask | mismatch_c;
                if (err_count == 4'd0) begin
                    first_fail_idx <= vector_idx;
                end
            end
            if (last_c) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next_c == 4'd0);
            end else begin
                vector_idx <= vector_idx + 3'd1;
                hold_cnt   <= '0;
            end
        end else if (state == DRIVE) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule
